// File: rtl/obm_dma_pkg.sv
// Shared GPU definitions for the OBM DMA: VRAM parameters, OBM sizing and FSM state type.
package obm_dma_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;
    localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE_DEFAULT = 12'h800;

    localparam int NUM_OBJECTS_DEFAULT = 64;
    localparam int OBM_BYTES = NUM_OBJECTS_DEFAULT * 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } obm_dma_state_t;

endpackage

// File: rtl/obm_dma.sv
// Copies one 256-byte system-memory page into OBM through the VRAM write port, halting the CPU
// for the duration of the burst.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last address/data
// READ  | mem_read high until mem_ready, then capture byte
// WRITE | one-cycle VRAM write of captured byte at OBM_BASE + index
// DONE  | one-cycle done pulse, CPU released
module obm_dma
    import obm_dma_pkg::*;
#(
    parameter int NUM_OBJECTS = NUM_OBJECTS_DEFAULT,
    parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE = OBM_BASE_DEFAULT
) (
    input  logic                       cpu_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 src_page,
    output logic [15:0]                mem_address,
    output logic                       mem_read,
    input  logic                       mem_ready,
    input  logic [7:0]                 mem_data,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                 vram_data,
    output logic                       write_enable,
    output logic                       SELECT_obm,
    output logic                       cpu_halt,
    output logic                       done
);

    localparam int BYTES = NUM_OBJECTS * 4;
    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    obm_dma_state_t state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       page_q;

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            page_q       <= '0;
            mem_address  <= '0;
            mem_read     <= 1'b0;
            vram_address <= '0;
            vram_data    <= '0;
            write_enable <= 1'b0;
            SELECT_obm   <= 1'b0;
            cpu_halt     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= READ;
                        idx         <= '0;
                        page_q      <= src_page;
                        mem_address <= {src_page, 8'h00};
                        mem_read    <= 1'b1;
                        cpu_halt    <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_ready) begin
                        state        <= WRITE;
                        mem_read     <= 1'b0;
                        vram_data    <= mem_data;
                        vram_address <= OBM_BASE + VRAM_ADDR_WIDTH'(idx);
                        write_enable <= 1'b1;
                        SELECT_obm   <= 1'b1;
                    end
                end
                WRITE: begin
                    write_enable <= 1'b0;
                    SELECT_obm   <= 1'b0;
                    // Equality compare on the last byte; the index never has to wrap.
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        cpu_halt <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state       <= READ;
                        idx         <= idx + 1'b1;
                        mem_address <= {page_q, 8'(idx + 1'b1)};
                        mem_read    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obm_dma.sv
// Directed bench for obm_dma: zero-wait and stalled copies, ignored start, mid-burst reset and reset/start race.
module tb_obm_dma;
    import obm_dma_pkg::*;

    logic                       cpu_clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic [7:0]                 src_page = 8'h00;
    logic [15:0]                mem_address;
    logic                       mem_read;
    logic                       mem_ready = 1'b1;
    logic [7:0]                 mem_data;
    logic [VRAM_ADDR_WIDTH-1:0] vram_address;
    logic [7:0]                 vram_data;
    logic                       write_enable;
    logic                       SELECT_obm;
    logic                       cpu_halt;
    logic                       done;

    logic [7:0] sysmem [0:65535];
    logic [7:0] obm [0:255];

    int n_vec = 0;
    int n_bad = 0;

    int halt_cnt, done_cnt, done_cyc, n_wr;

    obm_dma dut (
        .cpu_clk(cpu_clk), .rst(rst), .start(start), .src_page(src_page),
        .mem_address(mem_address), .mem_read(mem_read), .mem_ready(mem_ready),
        .mem_data(mem_data), .vram_address(vram_address), .vram_data(vram_data),
        .write_enable(write_enable), .SELECT_obm(SELECT_obm), .cpu_halt(cpu_halt),
        .done(done)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign mem_data = sysmem[mem_address];

    // OBM array captures on the falling edge
    always @(negedge cpu_clk)
        if (write_enable && vram_address >= 12'h800 && vram_address <= 12'h8FF)
            obm[vram_address - 12'h800] = vram_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_obm();
        for (int i = 0; i < 256; i++) obm[i] = 8'hEE;
    endtask

    // Called at a negedge; pulses start so it is sampled at the next posedge (E0),
    // then observes cycles 1..max at their negedges.
    task automatic run_burst(input logic [7:0] page, input bit stall,
                             input int ign_cyc, input int rst_cyc, input int max_cyc);
        int rd_num = 0;
        int stall_left = 0;
        bit in_read = 0;
        logic [15:0] held = '0;
        halt_cnt = 0; done_cnt = 0; done_cyc = 0; n_wr = 0;
        src_page = page;
        start = 1'b1;
        @(posedge cpu_clk);
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge cpu_clk);
            start = 1'b0;
            rst = 1'b0;
            if (c == ign_cyc) begin
                start = 1'b1;
                src_page = 8'h03;
            end
            if (c == rst_cyc) rst = 1'b1;
            if (rst_cyc > 0 && c == rst_cyc + 1) begin
                chk("rst_we", write_enable, 0);
                chk("rst_rd", mem_read, 0);
                chk("rst_halt", cpu_halt, 0);
                chk("rst_addr", mem_address, 0);
            end
            if (stall) begin
                if (mem_read) begin
                    if (!in_read) begin
                        in_read = 1;
                        stall_left = (rd_num % 17 == 16) ? 3 : 0;
                        rd_num++;
                        held = mem_address;
                    end else begin
                        chk("stall_addr", mem_address, held);
                    end
                    if (stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else begin
                        mem_ready = 1'b1;
                        in_read = 0;
                    end
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                mem_ready = 1'b1;
            end
            if (cpu_halt) halt_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (write_enable) begin
                chk("vram_addr", vram_address, 32'h800 + n_wr);
                n_wr++;
            end
            chk("sel_eq_we", SELECT_obm, write_enable);
            if (mem_read && n_wr == 255) chk("final_rd_addr", mem_address, {page, 8'hFF});
            if (done_cyc != 0 && c > done_cyc + 3) break;
            if (rst_cyc > 0 && c > rst_cyc + 4) break;
        end
        start = 1'b0;
        rst = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sysmem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            sysmem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            sysmem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        end
        clear_obm();

        // reset state
        repeat (3) @(negedge cpu_clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_halt", cpu_halt, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_vram_addr", vram_address, 0);
        chk("rst_vram_data", vram_data, 0);
        rst = 1'b0;
        @(negedge cpu_clk);

        // zero-wait copy
        run_burst(8'h02, 0, 0, 0, 600);
        chk("zw_done_cnt", done_cnt, 1);
        chk("zw_done_cyc", done_cyc, 513);
        chk("zw_halt", halt_cnt, 512);
        chk("zw_writes", n_wr, 256);
        for (int i = 0; i < 256; i++) chk("zw_obm", obm[i], 8'(i) ^ 8'h5A);
        chk("idle_vram_hold", vram_address, 12'h8FF);
        chk("idle_data_hold", vram_data, 8'hFF ^ 8'h5A);

        // wait states: 15 stalled reads of 3 cycles each
        clear_obm();
        run_burst(8'h02, 1, 0, 0, 700);
        chk("ws_done_cnt", done_cnt, 1);
        chk("ws_done_cyc", done_cyc, 513 + 45);
        chk("ws_halt", halt_cnt, 512 + 45);
        for (int i = 0; i < 256; i++) chk("ws_obm", obm[i], 8'(i) ^ 8'h5A);

        // ignored start mid-burst with a different page
        clear_obm();
        run_burst(8'h02, 0, 100, 0, 600);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_done_cyc", done_cyc, 513);
        for (int i = 0; i < 256; i++) chk("ign_obm", obm[i], 8'(i) ^ 8'h5A);
        repeat (3) @(negedge cpu_clk);
        chk("ign_no_restart", cpu_halt, 0);
        src_page = 8'h00;

        // reset during the read of byte 100
        clear_obm();
        run_burst(8'h02, 0, 0, 201, 600);
        chk("mr_done_cnt", done_cnt, 0);
        chk("mr_writes", n_wr, 100);
        for (int i = 0; i < 256; i++)
            chk("mr_obm", obm[i], (i < 100) ? (8'(i) ^ 8'h5A) : 8'hEE);
        chk("mr_vram_addr", vram_address, 0);
        chk("mr_vram_data", vram_data, 0);

        // reset and start together
        rst = 1'b1;
        start = 1'b1;
        src_page = 8'h03;
        @(negedge cpu_clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rs_halt", cpu_halt, 0);
        chk("rs_rd", mem_read, 0);
        repeat (2) @(negedge cpu_clk);
        chk("rs_idle_halt", cpu_halt, 0);
        clear_obm();
        run_burst(8'h03, 0, 0, 0, 600);
        chk("rs_done_cyc", done_cyc, 513);
        chk("rs_halt_cnt", halt_cnt, 512);
        for (int i = 0; i < 256; i++) chk("rs_obm", obm[i], 8'(i) ^ 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
